ecg_matrix_loader: RTL and testbench

- Upstream feeder for the 16x16 dot-product/classifier stage.
- Accepts a valid/ready stream of Q8.8 feature samples in row-major order and converts each to Q4.4 with round-half-up and saturation.
- Assembles the samples into a 16x16 matrix, pulses start to the classifier, and holds the matrix stable until the classifier reports done.
- Checks frame framing with in_last and recovers from malformed frames.

---
 rtl/ecg_matrix_loader_pkg.sv | 19 +
 rtl/ecg_matrix_loader_q88_to_q44_sat.sv | 35 +++
 rtl/ecg_matrix_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_ecg_matrix_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_matrix_loader_pkg.sv
// Shared constants, loader FSM state type and Q4.4 saturation limits for the
// ECG matrix loader and its Q8.8 -> Q4.4 converter.
package ecg_pkg;

  localparam int MATRIX_SIZE = 16;
  localparam int IN_WIDTH    = 16;
  localparam int DATA_WIDTH  = 8;

  localparam logic [DATA_WIDTH-1:0] Q44_MAX = 8'h7F;
  localparam logic [DATA_WIDTH-1:0] Q44_MIN = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    LAUNCH,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/ecg_matrix_loader_q88_to_q44_sat.sv
// Combinational Q8.8 -> Q4.4 conversion: round half up on the dropped
// fraction bits, then saturate to the signed output range.
module q88_to_q44_sat #(
  parameter int IN_W  = ecg_pkg::IN_WIDTH,
  parameter int OUT_W = ecg_pkg::DATA_WIDTH
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data
);
  import ecg_pkg::*;

  localparam int FRAC_SHIFT = 4;
  localparam logic signed [IN_W:0] ROUND = (IN_W+1)'(1 << (FRAC_SHIFT - 1));
  localparam logic signed [IN_W:0] T_MAX = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] T_MIN = (IN_W+1)'(-(2 ** (OUT_W - 1)));

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] sum;
  logic signed [IN_W:0] t;

  // One guard bit keeps the +ROUND from wrapping near the positive limit.
  always_comb begin
    ext = {in_data[IN_W-1], in_data};
    sum = ext + ROUND;
    t   = sum >>> FRAC_SHIFT;
    if (t > T_MAX) begin
      out_data = OUT_W'(Q44_MAX);
    end else if (t < T_MIN) begin
      out_data = OUT_W'(Q44_MIN);
    end else begin
      out_data = t[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ecg_matrix_loader.sv
// Streams Q8.8 samples into a Q4.4 matrix, launches the classifier and holds
// the matrix until done. ECG_LOADER_PINGPONG_EN selects a two-bank variant.
module ecg_matrix_loader #(
  parameter int MATRIX_SIZE = ecg_pkg::MATRIX_SIZE,
  parameter int IN_WIDTH    = ecg_pkg::IN_WIDTH,
  parameter int DATA_WIDTH  = ecg_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mat_out [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1],
  output logic                  start,
  input  logic                  cls_done,
  output logic                  busy,
  output logic                  frame_err
);
  import ecg_pkg::*;

  localparam int ELEMS = MATRIX_SIZE * MATRIX_SIZE;
  localparam int CNT_W = $clog2(ELEMS);
  localparam int IDX_W = $clog2(MATRIX_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ELEMS - 1);

  loader_state_t         state;
  loader_state_t         state_n;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] q44;
  logic [IDX_W-1:0]      row;
  logic [IDX_W-1:0]      col;
  logic                  accept;
  logic                  filling;
  logic                  acc_fill;
  logic                  cnt_last;
  logic                  complete;
  logic                  drain_enter;

  q88_to_q44_sat #(
    .IN_W  (IN_WIDTH),
    .OUT_W (DATA_WIDTH)
  ) u_conv (
    .in_data  (in_data),
    .out_data (q44)
  );

  assign accept      = in_valid && in_ready;
  assign acc_fill    = accept && filling;
  assign cnt_last    = (cnt == CNT_LAST);
  assign complete    = acc_fill && cnt_last && in_last;
  assign drain_enter = acc_fill && cnt_last && !in_last;
  // Early in_last and missing in_last both show up as a mismatch with cnt_last.
  assign frame_err   = acc_fill && (cnt_last != in_last);
  assign row         = cnt[CNT_W-1:IDX_W];
  assign col         = cnt[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (acc_fill) begin
      cnt <= (in_last || cnt_last) ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef ECG_LOADER_PINGPONG_EN

  logic [DATA_WIDTH-1:0] bank [0:1][0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];
  loader_state_t         in_st;
  loader_state_t         in_st_n;
  logic [1:0]            full;
  logic [1:0]            full_n;
  logic                  fill_bank;
  logic                  act_bank;
  logic                  act_n;
  logic                  pend;
  logic                  pend_n;

  // Input side runs FILL/DRAIN; state tracks the classifier side (FILL = idle).
  assign filling  = (in_st == FILL);
  assign in_ready = (in_st == DRAIN) || !full[fill_bank];
  assign mat_out  = bank[act_bank];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      in_st     <= FILL;
      full      <= '0;
      fill_bank <= 1'b0;
      act_bank  <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state    <= state_n;
      in_st    <= in_st_n;
      full     <= full_n;
      act_bank <= act_n;
      pend     <= pend_n;
      if (complete) begin
        fill_bank <= ~fill_bank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank <= '{default: '0};
    end else if (acc_fill) begin
      bank[fill_bank][row][col] <= q44;
    end
  end

  always_comb begin
    state_n = state;
    in_st_n = in_st;
    full_n  = full;
    act_n   = act_bank;
    pend_n  = pend;
    start   = 1'b0;
    busy    = 1'b0;

    if (drain_enter) begin
      in_st_n = DRAIN;
    end else if (in_st == DRAIN && accept && in_last) begin
      in_st_n = FILL;
    end

    if (complete) begin
      full_n[fill_bank] = 1'b1;
      pend_n            = 1'b1;
    end

    // A pending bank is always the one opposite the last active bank.
    case (state)
      FILL: begin
        if (pend) begin
          state_n = LAUNCH;
          act_n   = ~act_bank;
          pend_n  = 1'b0;
        end else if (complete) begin
          state_n = LAUNCH;
          act_n   = fill_bank;
          pend_n  = 1'b0;
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (cls_done) begin
          full_n[act_bank] = 1'b0;
          if (pend) begin
            state_n = LAUNCH;
            act_n   = ~act_bank;
            pend_n  = 1'b0;
          end else begin
            state_n = FILL;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

`else

  logic [DATA_WIDTH-1:0] mat [0:MATRIX_SIZE-1][0:MATRIX_SIZE-1];

  assign filling = (state == FILL);
  assign mat_out = mat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat <= '{default: '0};
    end else if (acc_fill) begin
      mat[row][col] <= q44;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (complete) begin
          state_n = LAUNCH;
        end else if (drain_enter) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (accept && in_last) begin
          state_n = FILL;
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (cls_done) begin
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

`endif

endmodule

// File: tb/tb_ecg_matrix_loader.sv
// Directed bench for ecg_matrix_loader: conversion, launch timing, framing
// errors, drain recovery, reset in WAIT_DONE and the two-bank variant.
module tb_ecg_matrix_loader;
  import ecg_pkg::*;

`ifdef ECG_LOADER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        cls_done = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        start;
  logic        busy;
  logic        frame_err;
  logic [7:0]  mat_out [0:15][0:15];

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;

  ecg_matrix_loader #(
    .MATRIX_SIZE (16),
    .IN_WIDTH    (16),
    .DATA_WIDTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mat_out   (mat_out),
    .start     (start),
    .cls_done  (cls_done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sample the cycle that is just ending.
  always @(posedge clk) begin
    if (start) start_cnt++;
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int count_bad(input logic [7:0] v);
    int n = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (mat_out[r][c] !== v) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
  endtask

  task automatic send_frame(input logic [15:0] d);
    for (int i = 0; i < 256; i++) push(d, i == 255);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_cls();
    cls_done = 1'b1;
    step();
    cls_done = 1'b0;
    step();
  endtask

  logic [15:0] cv_in  [6] = '{16'h0128, 16'h0800, 16'hF000, 16'hFFF7, 16'hFFF8, 16'h7FFF};
  logic [7:0]  cv_exp [6] = '{8'h13, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'h7F};
  int s0;
  int f0;

  initial begin
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mat", count_bad(8'h00), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", in_ready, 1);
    check("rel_start", start, 0);
    check("rel_ferr", frame_err, 0);
    step();

    // Frame of 0x0010 -> all 0x01, with launch timing and ready gating.
    send_frame(16'h0010);
    @(negedge clk);
    check("t1_start", start, 1);
    check("t1_ready_launch", in_ready, PP ? 1 : 0);
    check("t1_busy", busy, 1);
    step();
    @(negedge clk);
    check("t1_start_once", start, 0);
    step();
`ifndef ECG_LOADER_PINGPONG_EN
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    in_last  = 1'b1;
`endif
    repeat (7) step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    cls_done = 1'b1;
    @(negedge clk);
    check("t1_ready_wait", in_ready, PP ? 1 : 0);
    step();
    cls_done = 1'b0;
    @(negedge clk);
    check("t1_ready_after", in_ready, 1);
    check("t1_busy_after", busy, 0);
    check("t1_starts", start_cnt, 1);
    check("t1_mat", count_bad(8'h01), 0);
    step();

    // Conversion corner cases in the first six elements.
    for (int i = 0; i < 256; i++) push(i < 6 ? cv_in[i] : 16'h0010, i == 255);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("t2_start", start, 1);
    for (int i = 0; i < 6; i++) check($sformatf("t2_conv%0d", i), mat_out[0][i], cv_exp[i]);
    check("t2_last_elem", mat_out[15][15], 8'h01);
    step();
    finish_cls();

    // Early in_last on element 100, then a clean frame.
    s0 = start_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i <= 100; i++) push(16'h0020, i == 100);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t3_ferr", ferr_cnt - f0, 1);
    check("t3_no_start", start_cnt - s0, 0);
    check("t3_ready", in_ready, 1);
    check("t3_busy", busy, 0);
    step();
    send_frame(16'h0030);
    @(negedge clk);
    check("t3_start", start, 1);
    check("t3_mat", count_bad(8'h03), 0);
    step();
    finish_cls();

    // Missing in_last: drain five samples, then a clean frame.
    s0 = start_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 256; i++) push(16'h0040, 1'b0);
    for (int i = 0; i < 5; i++) push(16'h7FFF, i == 4);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("t4_ferr", ferr_cnt - f0, 1);
    check("t4_no_start", start_cnt - s0, 0);
    check("t4_drop", mat_out[0][0], PP ? 8'h03 : 8'h04);
    check("t4_ready", in_ready, 1);
    step();
    send_frame(16'h0050);
    @(negedge clk);
    check("t4_start", start, 1);
    check("t4_mat", count_bad(8'h05), 0);
    step();
    finish_cls();

    // Reset while the matrix is held.
    send_frame(16'h0060);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_start", start, 0);
    check("t5_rst_mat", count_bad(8'h00), 0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    step();
    send_frame(16'h0070);
    @(negedge clk);
    check("t5_start", start, 1);
    check("t5_mat", count_bad(8'h07), 0);
    step();
    finish_cls();
    check("total_starts", start_cnt, 6);
    check("total_ferr", ferr_cnt, 2);

`ifdef ECG_LOADER_PINGPONG_EN
    // Second frame fills the spare bank while the first is held.
    s0 = start_cnt;
    send_frame(16'h0010);
    send_frame(16'h0020);
    @(negedge clk);
    check("pp_ready_full", in_ready, 0);
    check("pp_mat_a", count_bad(8'h01), 0);
    check("pp_busy", busy, 1);
    step();
    cls_done = 1'b1;
    @(negedge clk);
    check("pp_no_early", start, 0);
    step();
    cls_done = 1'b0;
    @(negedge clk);
    check("pp_start_b", start, 1);
    check("pp_mat_b", count_bad(8'h02), 0);
    step();
    finish_cls();
    check("pp_starts", start_cnt - s0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
